// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and state encoding for the UART frame deframer
// Holds the default start-of-frame marker, the err_code values and the deframer state type.
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAY,
    CHK,
    DRAIN,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - simple dual-port payload RAM with synchronous write and registered read
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears the read register only
//   we/waddr/wdata  write port
//   re/raddr     read enable and address; rdata updates on the next edge when re is high
//   rdata        registered read data, held while re is low
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the downstream data register, so it holds on !re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_deframer.sv
// rtl/uart_frame_deframer.sv - hunts SOF/LEN/payload/CHK frames and releases only good payloads
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_data/in_valid/in_ready       byte stream from a show-ahead RX FIFO (rdreq = in_valid && in_ready)
//   out_data/out_valid/out_ready/out_last  payload stream, last marks the final byte of a frame
//   frame_ok, frame_err, err_code   one-cycle result pulses; err_code valid with frame_err
//   frame_cnt                       wrapping count of good frames
module uart_frame_deframer
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  state_t        state;
  logic [LW-1:0] len, wr_ptr, rd_ptr;
  logic [LW-1:0] wr_next, rd_next;
  logic [7:0]    chk;
  logic [TW-1:0] idle_cnt;
  logic          accept, tmo_hit, in_frame;
  logic          buf_re;
  logic [AW-1:0] buf_raddr;

  assign accept   = in_valid && in_ready;
  assign wr_next  = wr_ptr + 1'b1;
  assign rd_next  = rd_ptr + 1'b1;
  assign in_frame = (state == LEN) || (state == PAY) || (state == CHK);
  assign tmo_hit  = (idle_cnt == TW'(TIMEOUT_CLKS - 1));

  // Read one entry ahead: address 0 while waiting for CHK, rd_ptr+1 on every transfer,
  // so the RAM's output register always holds the byte currently offered downstream.
  always_comb begin
    buf_re    = 1'b0;
    buf_raddr = '0;
    if (state == CHK) begin
      buf_re = 1'b1;
    end else if (state == DRAIN && out_ready && !out_last) begin
      buf_re    = 1'b1;
      buf_raddr = rd_next[AW-1:0];
    end
  end

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && (state == PAY)),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      chk       <= 8'h00;
      idle_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      frame_cnt <= 16'h0000;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;

      // Idle counter only runs inside a frame; holding it at 0 elsewhere clears it on LEN entry.
      if (!in_frame || accept)               idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT_CLKS)) idle_cnt <= idle_cnt + 1'b1;

      case (state)
        HUNT: begin
          in_ready <= 1'b1;
          if (accept && in_data == SOF_BYTE) state <= LEN;
        end
        LEN: begin
          if (accept) begin
            if (in_data == 8'h00 || in_data > 8'(MAX_LEN)) begin
              state <= ERR; in_ready <= 1'b0; frame_err <= 1'b1; err_code <= ERR_LEN;
            end else begin
              len    <= in_data[LW-1:0];
              chk    <= in_data;
              wr_ptr <= '0;
              state  <= PAY;
            end
          end else if (tmo_hit) begin
            state <= ERR; in_ready <= 1'b0; frame_err <= 1'b1; err_code <= ERR_TMO;
          end
        end
        PAY: begin
          if (accept) begin
            chk    <= chk ^ in_data;
            wr_ptr <= wr_next;
            if (wr_next == len) state <= CHK;
          end else if (tmo_hit) begin
            state <= ERR; in_ready <= 1'b0; frame_err <= 1'b1; err_code <= ERR_TMO;
          end
        end
        CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state     <= DRAIN;
              rd_ptr    <= '0;
              out_valid <= 1'b1;
              out_last  <= (len == LW'(1));
            end else begin
              state <= ERR; frame_err <= 1'b1; err_code <= ERR_CHK;
            end
          end else if (tmo_hit) begin
            state <= ERR; in_ready <= 1'b0; frame_err <= 1'b1; err_code <= ERR_TMO;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              frame_ok  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= DONE;
            end else begin
              rd_ptr   <= rd_next;
              out_last <= (rd_next == len - 1'b1);
            end
          end
        end
        DONE, ERR: begin
          in_ready <= 1'b1;
          state    <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_deframer.sv
// tb/tb_uart_frame_deframer.sv - self-checking bench for uart_frame_deframer
module tb_uart_frame_deframer;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 8680;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  uart_frame_deframer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] stim[$];
  logic [7:0] rxq[$];
  logic [8:0] got_out[$], exp_out[$];
  int         got_ev[$], exp_ev[$];
  int         mode, cyc, last_acc, exp_cnt;
  logic       prev_stall, prev_valid, prev_xfer_nonlast;
  logic [8:0] prev_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan the byte stream by index, applying the frame rules directly.
  function automatic void model();
    int i = 0;
    int l;
    logic [7:0] x;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) i++;
      else if (i + 1 >= stim.size()) i = stim.size();
      else begin
        l = int'(stim[i+1]);
        if (l == 0 || l > MAX_LEN) begin
          exp_ev.push_back(1);
          i += 2;
        end else if (i + l + 2 >= stim.size()) i = stim.size();
        else begin
          x = stim[i+1];
          for (int k = 0; k < l; k++) x ^= stim[i+2+k];
          if (x == stim[i+2+l]) begin
            for (int k = 0; k < l; k++) exp_out.push_back({(k == l - 1), stim[i+2+k]});
            exp_ev.push_back(0);
            exp_cnt++;
          end else exp_ev.push_back(2);
          i += l + 3;
        end
      end
    end
  endfunction

  // One clock: drive/sample at negedge, pop the FIFO model on acceptance.
  task automatic step();
    logic acc, xfer;
    @(negedge clk);
    cyc++;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (out_valid && !prev_valid) check("first_beat_latency", cyc - last_acc, 1);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_beat", {out_last, out_data}, prev_beat);
    end
    if (prev_xfer_nonlast) check("drain_continues", out_valid, 1'b1);
    if (out_valid || frame_ok || frame_err) check("in_ready_low", in_ready, 1'b0);
    xfer = out_valid && out_ready;
    if (xfer) got_out.push_back({out_last, out_data});
    if (frame_ok) got_ev.push_back(0);
    if (frame_err) got_ev.push_back(int'(err_code));
    prev_stall        = out_valid && !out_ready;
    prev_beat         = {out_last, out_data};
    prev_xfer_nonlast = xfer && !out_last;
    prev_valid        = out_valid;
    in_valid = (rxq.size() > 0);
    in_data  = in_valid ? rxq[0] : 8'h00;
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) begin
      void'(rxq.pop_front());
      last_acc = cyc;
    end
  endtask

  task automatic clear_q();
    exp_out.delete(); exp_ev.delete(); got_out.delete(); got_ev.delete();
  endtask

  task automatic compare(input string tag);
    @(negedge clk);
    check({tag, "_nout"}, got_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      check({tag, "_beat"}, got_out[i], exp_out[i]);
    check({tag, "_nev"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      check({tag, "_ev"}, got_ev[i], exp_ev[i]);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic play(input string tag, input int m);
    int guard = 0;
    int quiet = 0;
    clear_q();
    model();
    foreach (stim[i]) rxq.push_back(stim[i]);
    mode = m;
    while (quiet < 40 && guard < 4000) begin
      step();
      guard++;
      if (rxq.size() == 0 && !prev_valid) quiet++;
      else quiet = 0;
    end
    if (guard >= 4000) check({tag, "_bound"}, guard, 0);
    compare(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_last"},  out_last,  1'b0);
    check({tag, "_out_data"},  out_data,  8'h00);
    check({tag, "_frame_ok"},  frame_ok,  1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_err_code"},  err_code,  2'd0);
    check({tag, "_frame_cnt"}, frame_cnt, 16'h0000);
  endtask

  initial begin
    int guard, l, ng;
    logic [7:0] x, g, b;
    rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    mode = 0; cyc = 0; last_acc = -10; exp_cnt = 0;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_xfer_nonlast = 1'b0; prev_beat = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Good frame, then explicit spot checks on the known payload.
    stim = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    play("good", 0);
    check("good_b0", (got_out.size() > 0) ? got_out[0] : 9'h0, 9'h011);
    check("good_b2", (got_out.size() > 2) ? got_out[2] : 9'h0, 9'h133);
    check("good_cnt1", frame_cnt, 16'd1);

    // Bad checksum followed by a good one-byte frame.
    stim = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    play("badchk", 0);

    // Garbage, zero length and over-long length.
    stim = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'hA5, 8'h11};
    play("badlen", 0);

    // Timeout mid-payload, then a clean frame.
    clear_q();
    stim = {8'hA5, 8'h02, 8'h10};
    foreach (stim[i]) rxq.push_back(stim[i]);
    mode = 0; guard = 0;
    while (got_ev.size() == 0 && guard < TMO + 200) begin step(); guard++; end
    if (guard >= TMO + 200) check("tmo_bound", guard, 0);
    check("tmo_code", (got_ev.size() > 0) ? got_ev[0] : -1, 3);
    check("tmo_min_wait", guard >= TMO, 1'b1);
    check("tmo_nout", got_out.size(), 0);
    stim = {8'hA5, 8'h01, 8'h55, 8'h54};
    play("post_tmo", 0);

    // Random frames under random back-pressure; first is a full 16-byte frame.
    stim.delete();
    for (int f = 0; f < 6; f++) begin
      l  = (f == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
      ng = (f == 0) ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom_range(0, 255));
        stim.push_back((g == 8'hA5) ? 8'h00 : g);
      end
      stim.push_back(8'hA5);
      stim.push_back(8'(l));
      x = 8'(l);
      for (int k = 0; k < l; k++) begin
        b = 8'($urandom_range(0, 255));
        stim.push_back(b);
        x ^= b;
      end
      if (f > 1 && $urandom_range(0, 3) == 0) x ^= 8'h01;
      stim.push_back(x);
    end
    play("rand_bp", 1);

    // Reset in the middle of a drain.
    clear_q();
    stim = {8'hA5, 8'h03, 8'h61, 8'h62, 8'h63, 8'h63};
    foreach (stim[i]) rxq.push_back(stim[i]);
    mode = 2; guard = 0;
    while (!prev_valid && guard < 200) begin step(); guard++; end
    if (guard >= 200) check("rst_bound", guard, 0);
    mode = 0;
    step();
    step();
    check("rst_pre_beats", got_out.size(), 2);
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_drain_rst");
    check("rst_no_ok", got_ev.size(), 0);
    rxq.delete();
    in_valid = 1'b0;
    exp_cnt = 0; last_acc = -10;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_xfer_nonlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stim = {8'hA5, 8'h02, 8'hA5, 8'h3C, 8'h9B};
    play("after_rst", 0);
    check("after_rst_cnt1", frame_cnt, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_deframer.md
Name: uart_frame_deframer

Overview:
- Sits between the RX byte FIFO and the byte consumer (TX FIFO or a command decoder) in the UART datapath.
- Hunts for frames of the form SOF, LEN, LEN payload bytes, CHK in the received byte stream.
- Buffers the payload internally and checks LEN and the XOR checksum.
- Releases the payload downstream only for good frames. Bad or stalled frames are dropped and reported.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame; also the internal buffer depth.
- TIMEOUT_CLKS, 8680: maximum clk cycles allowed between bytes inside a frame (≈20 bit times at 115200 baud, 50 MHz).
- SOF_BYTE, 8'hA5: start-of-frame marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte from the RX FIFO. The FIFO runs in show-ahead mode: q is valid while !empty.
- in_valid  in  1  driven by !empty of the RX FIFO
- in_ready  out  1  byte consumed this cycle; drives the FIFO rdreq as in_valid && in_ready
- out_data  out  8  payload byte
- out_valid  out  1  payload byte available
- out_ready  in  1  downstream accepts the byte; a transfer occurs when out_valid && out_ready
- out_last  out  1  marks the final payload byte of a frame
- frame_ok  out  1  one-cycle pulse when a good frame has been fully drained
- frame_err  out  1  one-cycle pulse when a frame is dropped
- err_code  out  2  valid while frame_err is high: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout
- frame_cnt  out  16  count of good frames; wraps at 16'hFFFF→0

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to HUNT and all counters to 0.
  - in_ready=0, out_valid=0, out_last=0, frame_ok=0, frame_err=0, err_code=0, frame_cnt=0.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-drain discards everything with no pulses.
- Byte acceptance: a byte is accepted in a cycle where in_valid && in_ready.
- in_ready:
  - 1 in HUNT, LEN, PAY and CHK.
  - 0 in DRAIN and for the single ERR/DONE cycle, which back-pressures the RX FIFO.
- States and transitions:
  - HUNT: accepted bytes ≠ SOF_BYTE are discarded silently. SOF_BYTE → LEN.
  - LEN:
    - Accepted byte L with L==0 or L>MAX_LEN → ERR with code 1.
    - Otherwise store len=L, set chk=L, clear wr_ptr, go to PAY.
  - PAY:
    - Each accepted byte is written to buf[wr_ptr], wr_ptr increments, chk ^= byte.
    - When wr_ptr reaches len → CHK.
  - CHK:
    - Accepted byte == chk → DRAIN with rd_ptr=0.
    - Otherwise → ERR with code 2.
  - DRAIN:
    - out_valid=1 and out_data=buf[rd_ptr]; out_last=1 when rd_ptr==len-1.
    - On each transfer rd_ptr increments. The transfer with out_last → DONE.
    - out_data, out_valid and out_last are registered and must not change while out_valid && !out_ready.
  - DONE: one cycle; frame_ok=1 and frame_cnt increments. → HUNT.
  - ERR: one cycle; frame_err=1 and err_code is set. → HUNT.
- SOF inside a frame: in LEN/PAY/CHK a SOF_BYTE value is ordinary data and is not a resync.
- Timeout:
  - The idle counter clears on every accepted byte and on entry to LEN.
  - It increments each cycle in LEN/PAY/CHK while no byte is accepted.
  - Reaching TIMEOUT_CLKS → ERR with code 3.
  - Byte acceptance in the same cycle wins over the timeout.
  - No timeout applies in HUNT or DRAIN.
- Latency:
  - The first out_valid asserts on the cycle after the CHK byte is accepted.
  - With out_ready held at 1, one byte transfers per cycle.
- Width rules:
  - len, wr_ptr and rd_ptr are $clog2(MAX_LEN+1) bits.
  - chk is 8 bits, computed as the XOR of LEN and all payload bytes.
  - The idle counter is $clog2(TIMEOUT_CLKS+1) bits and saturates.

Decomposition:
- Package uart_frame_pkg:
  - default SOF constant;
  - err_code localparams: ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TMO=3;
  - state enum {HUNT, LEN, PAY, CHK, DRAIN, DONE, ERR}.
- Sub-module frame_buf: simple dual-port MAX_LEN×8 RAM with synchronous write and registered read, inferable as MLAB/M9K.
- The deframer prefetches the read one cycle ahead to meet the DRAIN timing.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 with out_ready=1.
  - Required: out 11, 22, 33 with out_last on 33.
  - frame_ok pulses once; frame_cnt=1.
- Bad checksum: A5 03 11 22 33 04.
  - Required: no out_valid; frame_err with err_code=2.
  - Then A5 01 7E 7F → out 7E with last, frame_ok.
- Bad length: A5 00, then A5 11 (17 > MAX_LEN).
  - Required: two frame_err pulses with err_code=1; no output.
  - Garbage 00 FF 5A before the SOF is ignored silently.
- Timeout: A5 02 10, then in_valid=0 for 8680 clks.
  - Required: frame_err with err_code=3.
  - A following A5 01 55 54 gives out 55 and frame_ok.
- Back-pressure: a good 16-byte frame with out_ready toggling randomly.
  - Required: all 16 bytes in order, out_data stable while stalled, in_ready=0 throughout DRAIN.
  - A queued next frame is consumed only after the DONE cycle.
- Reset mid-DRAIN: assert rst_n=0 after 2 of 3 bytes have transferred.
  - Required: all outputs 0 immediately, no frame_ok, frame_cnt=0, and the next frame is parsed normally.
